// File: rtl/divmmc_pkg.sv
// rtl/divmmc_pkg.sv - shared constants and state encoding for the divMMC SPI path
//
// Purpose: port decode constants, card-select idle value, SPI idle levels
//          and the byte-engine state encoding.
// Ports:   none (package).

package divmmc_pkg;

   localparam logic [7:0] DIVIDE_CONTROL_PORT = 8'hE3;
   localparam logic [7:0] ZXMMC_CONTROL_PORT  = 8'hE7;
   localparam logic [7:0] ZXMMC_SPI_PORT      = 8'hEB;

   localparam logic [1:0] CARD_NONE = 2'b11;

   localparam logic SCLK_IDLE = 1'b0;
   localparam logic MOSI_IDLE = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_state_t;

endpackage

// File: rtl/divmmc_spi_clkgen.sv
// rtl/divmmc_spi_clkgen.sv - SCLK half-period divider for the divMMC SPI engine
//
// Purpose: counts system clocks 0..div-1 while enabled; on the last count it
//          wraps and toggles SCLK. While disabled the counter is held at 0
//          and SCLK sits at its idle level.
// Ports:   clock, reset (async, active-low)
//          enable  - engine is shifting
//          div     - latched half-period length in system clocks
//          tick    - high on the cycle whose rising edge toggles SCLK
//          sclk    - registered SCLK level

module divmmc_spi_clkgen
   import divmmc_pkg::*;
#(
   parameter int CNT_W = 7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [CNT_W-1:0] div,
   output logic             tick,
   output logic             sclk
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   assign tick = enable && (cnt == (div - ONE));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         sclk <= SCLK_IDLE;
      end else if (!enable) begin
         cnt  <= '0;
         sclk <= SCLK_IDLE;
      end else if (tick) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt  <= cnt + ONE;
      end
   end

endmodule

// File: rtl/divmmc_spi_master.sv
// rtl/divmmc_spi_master.sv - divMMC SPI mode-0 byte engine with card-select register
//
// Purpose: shifts one byte per accepted start MSB first, samples MISO on SCLK
//          rising toggles, returns the received byte with a one-cycle done.
// Ports:   clock, reset (async, active-low)
//          start, tx_byte, speed_sel      - transfer request, data, rate select
//          cs_we, cs_d                    - card-select register write
//          busy, done, rx_byte            - transfer status and result
//          card                           - active-low card selects
//          spi_clock, spi_dataout, spi_datain - SCLK, MOSI, MISO

module divmmc_spi_master
   import divmmc_pkg::*;
#(
   parameter int SLOW_DIV = 64,
   parameter int FAST_DIV = 1,
   parameter int CNT_W    = 7
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       speed_sel,
   input  logic       cs_we,
   input  logic [1:0] cs_d,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_byte,
   output logic [1:0] card,
   output logic       spi_clock,
   output logic       spi_dataout,
   input  logic       spi_datain
);

   localparam logic [CNT_W-1:0] SLOW_CNT = CNT_W'(SLOW_DIV);
   localparam logic [CNT_W-1:0] FAST_CNT = CNT_W'(FAST_DIV);

   spi_state_t       state;
   logic [6:0]       tx_shift;   // bits still to send; bit 7 is already on MOSI
   logic [7:0]       rx_shift;
   logic [2:0]       bit_cnt;
   logic [CNT_W-1:0] div_q;
   logic             tick;
   logic             finishing;
   logic             accept;

   divmmc_spi_clkgen #(
      .CNT_W (CNT_W)
   ) u_clkgen (
      .clock  (clock),
      .reset  (reset),
      .enable (state == SHIFT),
      .div    (div_q),
      .tick   (tick),
      .sclk   (spi_clock)
   );

   // The 8th falling toggle ends the byte; a start on that same edge chains
   // the next byte so SCLK never gets an extra cycle between bytes.
   assign finishing = (state == SHIFT) && tick && spi_clock && (bit_cnt == 3'd7);
   assign accept    = start && ((state == IDLE) || finishing);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         tx_shift    <= '1;
         rx_shift    <= 8'hFF;
         bit_cnt     <= '0;
         div_q       <= SLOW_CNT;
         busy        <= 1'b0;
         done        <= 1'b0;
         rx_byte     <= 8'hFF;
         card        <= CARD_NONE;
         spi_dataout <= MOSI_IDLE;
      end else begin
         done <= 1'b0;

         if (finishing) begin
            state       <= IDLE;
            spi_dataout <= MOSI_IDLE;
            rx_byte     <= rx_shift;
            done        <= 1'b1;
            busy        <= 1'b0;
         end else if ((state == SHIFT) && tick) begin
            if (!spi_clock) begin
               rx_shift <= {rx_shift[6:0], spi_datain};
            end else begin
               spi_dataout <= tx_shift[6];
               tx_shift    <= {tx_shift[5:0], 1'b1};
               bit_cnt     <= bit_cnt + 3'd1;
            end
         end

         // Later assignments override the finish path on a chained start.
         if (accept) begin
            state       <= SHIFT;
            tx_shift    <= tx_byte[6:0];
            spi_dataout <= tx_byte[7];
            busy        <= 1'b1;
            bit_cnt     <= '0;
            div_q       <= speed_sel ? FAST_CNT : SLOW_CNT;
         end

         if (cs_we) begin
            card <= cs_d;
         end
      end
   end

endmodule
